// File: rtl/systolic_operand_feeder_pkg.sv
// Shared definitions for the systolic operand feeder.
// Provides the default array geometry, the feeder state encoding, and a
// constant-evaluable ceiling-log2 used to size counters.
package systolic_pkg;

    localparam int N_DEFAULT      = 4;
    localparam int DATA_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        FULL   = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    // Number of bits needed to encode values 0..value-1 (clog2(1) = 0).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/systolic_operand_feeder_if.sv
// Operand feeder bus: load stream, pass control, and the skewed A/B lanes
// that enter the processing-element array.
//   ld_valid/ld_ready/ld_data : load stream into the operand buffer
//   start/busy/done/clr_accum : pass control and status
//   a_out/a_vld               : row lanes into the array's left edge
//   b_out/b_vld               : column lanes into the array's top edge
// Handshake: a load beat transfers on a rising clk edge where ld_valid and
// ld_ready are both high; ld_data must be stable while ld_valid is high, and
// ld_ready does not depend on ld_valid.
// The feeder uses the master modport; the load source / array side uses slave.
interface systolic_operand_feeder_if
    import systolic_pkg::*;
#(
    parameter int N      = N_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
);

    logic                  ld_valid;
    logic                  ld_ready;
    logic [DATA_W-1:0]     ld_data;
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  clr_accum;
    logic [N*DATA_W-1:0]   a_out;
    logic [N-1:0]          a_vld;
    logic [N*DATA_W-1:0]   b_out;
    logic [N-1:0]          b_vld;

    modport master (
        input  ld_valid, ld_data, start,
        output ld_ready, busy, done, clr_accum, a_out, a_vld, b_out, b_vld
    );

    modport slave (
        output ld_valid, ld_data, start,
        input  ld_ready, busy, done, clr_accum, a_out, a_vld, b_out, b_vld
    );

endinterface

// File: rtl/systolic_operand_feeder_skew_lane.sv
// One skewed operand lane.
// Takes one N-entry operand vector (a row of A or a column of B) and the lane
// index LANE; for the stream step t it registers element t-LANE with valid
// high when LANE <= t < LANE+N, and zero with valid low otherwise.
//   clk, reset_n : clock, synchronous active-low reset
//   vec          : N operands, element k at bits [k*DATA_W +: DATA_W]
//   en           : the next cycle is a stream cycle
//   t            : stream step that the next cycle represents
//   value, valid : registered lane output
module skew_lane
    import systolic_pkg::*;
#(
    parameter int N      = N_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int LANE   = 0,
    parameter int T_W    = clog2(2 * N)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [N*DATA_W-1:0] vec,
    input  logic                en,
    input  logic [T_W-1:0]      t,
    output logic [DATA_W-1:0]   value,
    output logic                valid
);

    logic [DATA_W-1:0] value_n;
    logic              valid_n;

    // Element k is presented at step LANE+k; all other steps output zero.
    always_comb begin
        value_n = '0;
        valid_n = 1'b0;
        if (en) begin
            for (int k = 0; k < N; k++) begin
                if (int'(t) == LANE + k) begin
                    value_n = vec[k*DATA_W +: DATA_W];
                    valid_n = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            value <= '0;
            valid <= 1'b0;
        end else begin
            value <= value_n;
            valid <= valid_n;
        end
    end

endmodule

// File: rtl/systolic_operand_feeder.sv
// Systolic operand feeder.
// Buffers one N x N A matrix and one N x N B matrix (row-major, A first) from
// the load stream, then on start drives diagonally skewed A operands into the
// row lanes and B operands into the column lanes for 2N-1 cycles, pulses
// clr_accum on the first stream cycle, waits N cycles for the array to drain
// and pulses done on the first cycle back in LOAD.
//   clk, reset_n : clock, synchronous active-low reset
//   bus          : feeder side of systolic_operand_feeder_if
//   state_dbg    : current FSM state
module systolic_operand_feeder
    import systolic_pkg::*;
#(
    parameter int N      = N_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic                         clk,
    input  logic                         reset_n,
    systolic_operand_feeder_if.master    bus,
    output state_t                       state_dbg
);

    localparam int NN         = N * N;
    localparam int LD_W       = clog2(2 * NN + 1);
    localparam int T_W        = clog2(2 * N);
    localparam int LD_LAST    = 2 * NN - 1;
    localparam int T_LAST     = 2 * N - 2;
    localparam int DRAIN_LAST = N - 1;

    state_t            state_q, state_n;
    logic [LD_W-1:0]   ld_cnt_q, ld_cnt_n;
    logic [T_W-1:0]    t_q, t_n;
    logic              done_q, done_n;
    logic              clr_q, clr_n;
    logic              lane_en;
    logic              ld_fire;

    logic [DATA_W-1:0] a_mem [NN];
    logic [DATA_W-1:0] b_mem [NN];

    assign ld_fire = bus.ld_valid && (state_q == LOAD);

    // Next-state and counter logic. t_n is the stream/drain step of the
    // coming cycle, which is what the lanes register.
    always_comb begin
        state_n  = state_q;
        ld_cnt_n = ld_cnt_q;
        t_n      = t_q;
        done_n   = 1'b0;
        clr_n    = 1'b0;
        lane_en  = 1'b0;
        case (state_q)
            LOAD: begin
                if (ld_fire) begin
                    if (ld_cnt_q == LD_W'(LD_LAST)) begin
                        state_n  = FULL;
                        ld_cnt_n = '0;
                    end else begin
                        ld_cnt_n = ld_cnt_q + LD_W'(1);
                    end
                end
            end
            FULL: begin
                if (bus.start) begin
                    state_n = STREAM;
                    t_n     = '0;
                    clr_n   = 1'b1;
                    lane_en = 1'b1;
                end
            end
            STREAM: begin
                if (t_q == T_W'(T_LAST)) begin
                    state_n = DRAIN;
                    t_n     = '0;
                end else begin
                    t_n     = t_q + T_W'(1);
                    lane_en = 1'b1;
                end
            end
            DRAIN: begin
                if (t_q == T_W'(DRAIN_LAST)) begin
                    state_n = LOAD;
                    t_n     = '0;
                    done_n  = 1'b1;
                end else begin
                    t_n = t_q + T_W'(1);
                end
            end
            default: begin
                state_n = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= LOAD;
            ld_cnt_q <= '0;
            t_q      <= '0;
            done_q   <= 1'b0;
            clr_q    <= 1'b0;
        end else begin
            state_q  <= state_n;
            ld_cnt_q <= ld_cnt_n;
            t_q      <= t_n;
            done_q   <= done_n;
            clr_q    <= clr_n;
        end
    end

    // Operand buffer; contents survive reset, only the counter is cleared.
    always_ff @(posedge clk) begin
        if (ld_fire) begin
            for (int k = 0; k < NN; k++) begin
                if (ld_cnt_q == LD_W'(k)) begin
                    a_mem[k] <= bus.ld_data;
                end
                if (ld_cnt_q == LD_W'(NN + k)) begin
                    b_mem[k] <= bus.ld_data;
                end
            end
        end
    end

    // Row i of A feeds row lane i; column j of B feeds column lane j.
    logic [N*DATA_W-1:0] a_row [N];
    logic [N*DATA_W-1:0] b_col [N];
    logic [DATA_W-1:0]   a_val [N];
    logic [DATA_W-1:0]   b_val [N];
    logic [N-1:0]        a_v;
    logic [N-1:0]        b_v;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_row[i] = '0;
            b_col[i] = '0;
            for (int k = 0; k < N; k++) begin
                a_row[i][k*DATA_W +: DATA_W] = a_mem[i*N + k];
                b_col[i][k*DATA_W +: DATA_W] = b_mem[k*N + i];
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        skew_lane #(.N(N), .DATA_W(DATA_W), .LANE(i), .T_W(T_W)) u_a_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .vec     (a_row[i]),
            .en      (lane_en),
            .t       (t_n),
            .value   (a_val[i]),
            .valid   (a_v[i])
        );
        skew_lane #(.N(N), .DATA_W(DATA_W), .LANE(i), .T_W(T_W)) u_b_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .vec     (b_col[i]),
            .en      (lane_en),
            .t       (t_n),
            .value   (b_val[i]),
            .valid   (b_v[i])
        );
    end

    logic [N*DATA_W-1:0] a_out_w;
    logic [N*DATA_W-1:0] b_out_w;

    always_comb begin
        a_out_w = '0;
        b_out_w = '0;
        for (int i = 0; i < N; i++) begin
            a_out_w[i*DATA_W +: DATA_W] = a_val[i];
            b_out_w[i*DATA_W +: DATA_W] = b_val[i];
        end
    end

    assign bus.a_out     = a_out_w;
    assign bus.b_out     = b_out_w;
    assign bus.a_vld     = a_v;
    assign bus.b_vld     = b_v;
    assign bus.ld_ready  = (state_q == LOAD);
    assign bus.busy      = (state_q == STREAM) || (state_q == DRAIN);
    assign bus.done      = done_q;
    assign bus.clr_accum = clr_q;
    assign state_dbg     = state_q;

endmodule
